// File: rtl/crc8_serial_if.sv
// Receive-side signal bundle for the bit-serial CRC-8 checker.
// The master (deserializer side) drives bits; the slave (checker) returns the verdict.
interface crc8_serial_if;
  logic       in_bit;
  logic       in_valid;
  logic       abort;
  logic       busy;
  logic       done;
  logic       crc_ok;
  logic       crc_err;
  logic [7:0] crc_calc;
  logic [7:0] rx_crc;

  modport master (
    output in_bit, in_valid, abort,
    input  busy, done, crc_ok, crc_err, crc_calc, rx_crc
  );

  modport slave (
    input  in_bit, in_valid, abort,
    output busy, done, crc_ok, crc_err, crc_calc, rx_crc
  );
endinterface

// File: rtl/crc8_serial_checker.sv
// Serial CRC-8 checker: recomputes the LFSR over DATA_BITS payload bits, captures the
// 8 trailing CRC bits (LSB first) and reports a registered one-cycle pass/fail verdict.
module crc8_serial_checker #(
  parameter int         DATA_BITS = 8,
  parameter logic [7:0] SEED      = 8'hD8,
  parameter logic [7:0] TAPS      = 8'b0100_0100
) (
  input  logic         clk_i,
  input  logic         rst_i,
  crc8_serial_if.slave link_if
);

  typedef enum logic [1:0] {IDLE, DATA, CRC, REPORT} state_t;

  localparam logic [7:0] LAST_CNT = 8'(DATA_BITS);

  function automatic logic [7:0] lfsr_step(input logic [7:0] c, input logic b);
    logic f;
    f = b ^ c[0];
    lfsr_step = {f, c[7:1] ^ (TAPS[6:0] & {7{f}})};
  endfunction

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rx_crc_q, rx_crc_d;
  logic [7:0] crc_calc_q, crc_calc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    rx_crc_d   = rx_crc_q;
    crc_calc_d = crc_calc_q;
    done_d     = 1'b0;
    ok_d       = 1'b0;
    err_d      = 1'b0;

    if (link_if.abort) begin
      state_d = IDLE;
      lfsr_d  = SEED;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (link_if.in_valid) begin
            lfsr_d     = lfsr_step(lfsr_q, link_if.in_bit);
            rx_crc_d   = 8'd0;
            crc_calc_d = 8'd0;
            if (LAST_CNT == 8'd1) begin
              state_d = CRC;
              cnt_d   = 8'd0;
            end else begin
              state_d = DATA;
              cnt_d   = 8'd1;
            end
          end
        end
        DATA: begin
          if (link_if.in_valid) begin
            lfsr_d = lfsr_step(lfsr_q, link_if.in_bit);
            if (cnt_q + 8'd1 == LAST_CNT) begin
              state_d = CRC;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        CRC: begin
          // LFSR is frozen here; the verdict must include the bit arriving this cycle.
          if (link_if.in_valid) begin
            rx_crc_d[cnt_q[2:0]] = link_if.in_bit;
            cnt_d                = cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              state_d    = REPORT;
              cnt_d      = 8'd0;
              crc_calc_d = lfsr_q;
              done_d     = 1'b1;
              ok_d       = (rx_crc_d == lfsr_q);
              err_d      = (rx_crc_d != lfsr_q);
            end
          end
        end
        REPORT: begin
          state_d = IDLE;
          lfsr_d  = SEED;
          cnt_d   = 8'd0;
        end
        default: begin
          state_d = IDLE;
          lfsr_d  = SEED;
          cnt_d   = 8'd0;
        end
      endcase
    end

    busy_d = (state_d == DATA) || (state_d == CRC);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      cnt_q      <= 8'd0;
      rx_crc_q   <= 8'd0;
      crc_calc_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      rx_crc_q   <= rx_crc_d;
      crc_calc_q <= crc_calc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  assign link_if.busy     = busy_q;
  assign link_if.done     = done_q;
  assign link_if.crc_ok   = ok_q;
  assign link_if.crc_err  = err_q;
  assign link_if.crc_calc = crc_calc_q;
  assign link_if.rx_crc   = rx_crc_q;

endmodule

// File: tb/tb_crc8_serial_checker.sv
// Scoreboard bench for crc8_serial_checker: each frame pushes its expected verdict,
// and a monitor pops and compares whenever DONE is observed.
module tb_crc8_serial_checker;

  typedef struct {
    logic       ok;
    logic [7:0] calc;
    logic [7:0] rx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc8_serial_if bus ();

  crc8_serial_checker #(
    .DATA_BITS(8),
    .SEED     (8'hD8),
    .TAPS     (8'b0100_0100)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .link_if(bus)
  );

  int   tests     = 0;
  int   fails     = 0;
  int   done_seen = 0;
  int   pushed    = 0;
  exp_t sb[$];
  exp_t mon_e;

  // CRC of 0x00 from seed 0xD8 is 0x14; of 0x01 it is 0xBF (hand-stepped LFSR).
  localparam logic [7:0] CRC_00 = 8'h14;
  localparam logic [7:0] CRC_01 = 8'hBF;

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_seen++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done=1, required no pending frame");
      end else begin
        mon_e = sb.pop_front();
        if (bus.crc_ok !== mon_e.ok) begin
          fails++;
          $display("FAIL crc_ok: got %b, required %b", bus.crc_ok, mon_e.ok);
        end
        tests++;
        if (bus.crc_err !== !mon_e.ok) begin
          fails++;
          $display("FAIL crc_err: got %b, required %b", bus.crc_err, !mon_e.ok);
        end
        tests++;
        if (bus.crc_calc !== mon_e.calc) begin
          fails++;
          $display("FAIL crc_calc: got %h, required %h", bus.crc_calc, mon_e.calc);
        end
        tests++;
        if (bus.rx_crc !== mon_e.rx) begin
          fails++;
          $display("FAIL rx_crc: got %h, required %h", bus.rx_crc, mon_e.rx);
        end
      end
    end
  end

  task automatic push_exp(input logic ok, input logic [7:0] calc, input logic [7:0] rx);
    exp_t e;
    e.ok   = ok;
    e.calc = calc;
    e.rx   = rx;
    sb.push_back(e);
    pushed++;
  endtask

  // Called with time at #1 after a rising edge; returns at #1 after the sampling edge.
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_bit   = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] pl, input logic [7:0] crc, input int maxgap);
    for (int i = 0; i < 8; i++) send_bit(pl[i], $urandom_range(maxgap, 0));
    for (int k = 0; k < 8; k++) send_bit(crc[k], $urandom_range(maxgap, 0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    bus.in_bit   = 1'b0;
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    idle(3);
    tests++;
    if ({bus.busy, bus.done, bus.crc_ok, bus.crc_err, bus.crc_calc, bus.rx_crc} !== 20'h0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b ok=%b err=%b calc=%h rx=%h, required all 0",
               bus.busy, bus.done, bus.crc_ok, bus.crc_err, bus.crc_calc, bus.rx_crc);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame;
    push_exp(1'b1, CRC_00, CRC_00);
    send_bit(1'b0, 0);
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_rise: got %b, required 1", bus.busy);
    end
    for (int i = 1; i < 8; i++) send_bit(1'b0, 0);
    for (int k = 0; k < 8; k++) send_bit(CRC_00[k], 0);
    idle(2);
    tests++;
    if (bus.busy !== 1'b0 || bus.crc_calc !== CRC_00) begin
      fails++;
      $display("FAIL after_frame: got busy=%b calc=%h, required busy=0 calc=%h",
               bus.busy, bus.crc_calc, CRC_00);
    end
  endtask

  task automatic test_bad_crc;
    push_exp(1'b0, CRC_00, 8'h15);
    send_frame(8'h00, 8'h15, 0);
    idle(2);
    // Only the last CRC bit is wrong, so the compare must include it.
    push_exp(1'b0, CRC_00, 8'h94);
    send_frame(8'h00, 8'h94, 0);
    idle(2);
  endtask

  task automatic test_gaps;
    push_exp(1'b1, CRC_01, CRC_01);
    send_frame(8'h01, CRC_01, 3);
    @(negedge clk);
    tests++;
    if (bus.done !== 1'b1) begin
      fails++;
      $display("FAIL done_latency: got done=%b one cycle after last bit, required 1", bus.done);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    push_exp(1'b1, CRC_00, CRC_00);
    push_exp(1'b1, CRC_01, CRC_01);
    send_frame(8'h00, CRC_00, 0);
    // Bit offered during REPORT must be dropped.
    bus.in_bit   = 1'b1;
    bus.in_valid = 1'b1;
    idle(1);
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    send_frame(8'h01, CRC_01, 0);
    idle(2);
  endtask

  task automatic test_abort;
    for (int i = 0; i < 6; i++) send_bit(i == 0, 0);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    idle(1);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
    idle(3);
    push_exp(1'b1, CRC_01, CRC_01);
    send_frame(8'h01, CRC_01, 1);
    idle(2);
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < 8; i++) send_bit(1'b0, 0);
    for (int k = 0; k < 3; k++) send_bit(CRC_00[k], 0);
    tests++;
    if (bus.rx_crc !== 8'h04 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got rx=%h busy=%b, required rx=04 busy=1", bus.rx_crc, bus.busy);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.crc_ok, bus.crc_err, bus.crc_calc, bus.rx_crc} !== 20'h0) begin
      fails++;
      $display("FAIL async_reset: got busy=%b done=%b ok=%b err=%b calc=%h rx=%h, required all 0",
               bus.busy, bus.done, bus.crc_ok, bus.crc_err, bus.crc_calc, bus.rx_crc);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    push_exp(1'b1, CRC_00, CRC_00);
    send_frame(8'h00, CRC_00, 0);
    idle(2);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_gaps();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    idle(4);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_done: got %0d verdicts outstanding, required 0", sb.size());
    end
    tests++;
    if (done_seen != pushed) begin
      fails++;
      $display("FAIL done_count: got %0d DONE pulses, required %0d", done_seen, pushed);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
